dsc_dma_writer: RTL and testbench

- Stage directly downstream of the descriptor queue manager.
- Consumes pkt_meta_with_queues_t entries that carry an updated dsc_q_state.
- Builds one 64-byte descriptor per entry flagged needs_dsc and emits it as a DMA write request (host address + 512-bit payload) toward the PCIe TX arbiter.
- Keeps running emitted/dropped counters for the CSR block.

---
 rtl/pcie_consts.sv | 42 ++++
 rtl/dsc_out_fifo.sv | 53 +++++
 rtl/dsc_dma_writer.sv | 107 ++++++++++
 tb/tb_dsc_dma_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_consts.sv
// Shared PCIe TX constants, descriptor layout and metadata bundle types.
// Types: pkt_meta_with_queues_t (input), pcie_dsc_t, dsc_dma_req_t (output).
package pcie_consts;

  localparam int DEF_NB_QUEUES  = 512;
  localparam int DSC_QID_W      = $clog2(DEF_NB_QUEUES);
  localparam int PKT_QID_W      = 12;
  localparam int DSC_SIZE_BYTES = 64;
  localparam int DSC_ADDR_SHIFT = $clog2(DSC_SIZE_BYTES);

  localparam logic [31:0] DSC_SIGNATURE = 32'hd5c0_0001;

  typedef struct packed {
    logic [31:0] head;
    logic [31:0] tail;
  } q_state_t;

  typedef struct packed {
    logic                 needs_dsc;
    logic [DSC_QID_W-1:0] dsc_queue_id;
    logic [PKT_QID_W-1:0] pkt_queue_id;
    logic [15:0]          size;
    logic [31:0]          kmem_high_addr;
    logic [31:0]          kmem_low_addr;
    q_state_t             dsc_q_state;
    q_state_t             pkt_q_state;
  } pkt_meta_with_queues_t;

  typedef struct packed {
    logic [383:0] rsvd;
    logic [31:0]  sig;
    logic [31:0]  size;
    logic [31:0]  qid;
    logic [31:0]  pkt_tail;
  } pcie_dsc_t;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
  } dsc_dma_req_t;

endpackage

// File: rtl/dsc_out_fifo.sv
// Valid/ready FIFO of dsc_dma_req_t, DEPTH entries (power of two, >= 2).
// Ports: clk, rst, push_valid_i/push_ready_o/push_data_i, pop_valid_o/pop_ready_i/pop_data_o.
module dsc_out_fifo
  import pcie_consts::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  dsc_dma_req_t push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output dsc_dma_req_t pop_data_o
);

  localparam int AW = $clog2(DEPTH);

  dsc_dma_req_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_valid_o  = !empty;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign push_ready_o = !full || pop_ready_i;
  assign pop          = pop_valid_o && pop_ready_i;
  assign push         = push_valid_i && push_ready_o;
  assign pop_data_o   = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dsc_dma_writer.sv
// Builds 64-byte descriptors from queue-manager metadata and emits DMA writes.
// Ports: in_meta_*, out_dsc_*, rb_size, dsc_count, dsc_drop_count. Macro: DSC_ADDR_CHECK_EN.
module dsc_dma_writer
  import pcie_consts::*;
#(
  parameter int NB_QUEUES  = DEF_NB_QUEUES,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pkt_meta_with_queues_t in_meta_data,
  input  logic                  in_meta_valid,
  output logic                  in_meta_ready,
  output logic [63:0]           out_dsc_addr,
  output logic [511:0]          out_dsc_data,
  output logic                  out_dsc_valid,
  input  logic                  out_dsc_ready,
  input  logic [25:0]           rb_size,
  output logic [31:0]           dsc_count,
  output logic [31:0]           dsc_drop_count
);

  dsc_dma_req_t s1_req_q, s1_req_d, fifo_out;
  logic         s1_valid_q, s1_valid_d;
  logic [31:0]  dsc_count_q, drop_count_q;
  logic         fifo_ready, s1_move, accept, load, drop, pop;
  logic [25:0]  slot;
  logic [63:0]  base;
  pcie_dsc_t    dsc;

  assign base = {in_meta_data.kmem_high_addr, in_meta_data.kmem_low_addr};

`ifdef DSC_ADDR_CHECK_EN
  assign drop = accept && in_meta_data.needs_dsc && (base == 64'd0);
`else
  assign drop = 1'b0;
`endif

  assign s1_move       = s1_valid_q && fifo_ready;
  assign in_meta_ready = !rst && (!s1_valid_q || s1_move);
  assign accept        = in_meta_valid && in_meta_ready;
  assign load          = accept && in_meta_data.needs_dsc && !drop;
  assign pop           = out_dsc_valid && out_dsc_ready;

  // Tail is the pre-increment slot; masking keeps it inside the ring.
  assign slot = in_meta_data.dsc_q_state.tail[25:0] & (rb_size - 26'd1);

  always_comb begin
    dsc          = '0;
    dsc.pkt_tail = in_meta_data.pkt_q_state.tail;
    dsc.qid      = 32'(in_meta_data.pkt_queue_id);
    dsc.size     = 32'(in_meta_data.size);
    dsc.sig      = DSC_SIGNATURE;
  end

  always_comb begin
    s1_valid_d = s1_valid_q && !s1_move;
    s1_req_d   = s1_req_q;
    if (load) begin
      s1_valid_d    = 1'b1;
      s1_req_d.addr = base + (64'(slot) << DSC_ADDR_SHIFT);
      s1_req_d.data = dsc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      dsc_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      dsc_count_q  <= dsc_count_q + 32'(pop);
      drop_count_q <= drop_count_q + 32'(drop);
    end
  end

  always_ff @(posedge clk) begin
    s1_req_q <= s1_req_d;
  end

  dsc_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_valid_i(s1_valid_q),
    .push_ready_o(fifo_ready),
    .push_data_i (s1_req_q),
    .pop_valid_o (out_dsc_valid),
    .pop_ready_i (out_dsc_ready),
    .pop_data_o  (fifo_out)
  );

  assign out_dsc_addr   = fifo_out.addr;
  assign out_dsc_data   = fifo_out.data;
  assign dsc_count      = dsc_count_q;
  assign dsc_drop_count = drop_count_q;

  logic [$clog2(NB_QUEUES)-1:0] unused_qid;
  logic                         unused_bits;
  assign unused_qid  = in_meta_data.dsc_queue_id;
  assign unused_bits = ^{in_meta_data.dsc_q_state.head,
                         in_meta_data.dsc_q_state.tail[31:26],
                         in_meta_data.pkt_q_state.head};

endmodule

// File: tb/tb_dsc_dma_writer.sv
// Scoreboard bench for dsc_dma_writer: directed vectors, queue-based monitor.
// Honours DSC_ADDR_CHECK_EN for the zero-address case.
module tb_dsc_dma_writer;
  import pcie_consts::*;

  typedef struct packed {
    logic [63:0]  addr;
    logic [127:0] data;
  } exp_t;

  logic                  clk = 0;
  logic                  rst;
  pkt_meta_with_queues_t in_meta_data;
  logic                  in_meta_valid;
  logic                  in_meta_ready;
  logic [63:0]           out_dsc_addr;
  logic [511:0]          out_dsc_data;
  logic                  out_dsc_valid;
  logic                  out_dsc_ready;
  logic [25:0]           rb_size;
  logic [31:0]           dsc_count;
  logic [31:0]           dsc_drop_count;

  dsc_dma_writer dut (
    .clk           (clk),
    .rst           (rst),
    .in_meta_data  (in_meta_data),
    .in_meta_valid (in_meta_valid),
    .in_meta_ready (in_meta_ready),
    .out_dsc_addr  (out_dsc_addr),
    .out_dsc_data  (out_dsc_data),
    .out_dsc_valid (out_dsc_valid),
    .out_dsc_ready (out_dsc_ready),
    .rb_size       (rb_size),
    .dsc_count     (dsc_count),
    .dsc_drop_count(dsc_drop_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_drop = 0;
  int   last_cycles;
  exp_t sb[$];
  int   pop_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  logic         prev_stall = 0;
  logic [63:0]  prev_addr;
  logic [511:0] prev_data;

  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      chk("stall_valid", 512'(out_dsc_valid), 512'd1);
      chk("stall_addr", 512'(out_dsc_addr), 512'(prev_addr));
      chk("stall_data", out_dsc_data, prev_data);
    end
    if (!rst && out_dsc_valid && out_dsc_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 512'(out_dsc_addr), 512'd0);
        if (out_dsc_addr == 64'd0) chk("unexpected_out", 512'd1, 512'd0);
      end else begin
        e = sb.pop_front();
        chk("out_addr", 512'(out_dsc_addr), 512'(e.addr));
        chk("out_data", out_dsc_data, {384'd0, e.data});
        pop_cyc_q.push_back(cyc);
      end
    end
    prev_stall = !rst && out_dsc_valid && !out_dsc_ready;
    prev_addr  = out_dsc_addr;
    prev_data  = out_dsc_data;
  end

  function automatic pkt_meta_with_queues_t mk(
      input logic needs, input logic [63:0] base, input logic [31:0] tail,
      input logic [31:0] ptail, input logic [11:0] qid, input logic [15:0] sz);
    pkt_meta_with_queues_t m;
    m = '0;
    m.needs_dsc        = needs;
    m.pkt_queue_id     = qid;
    m.size             = sz;
    m.kmem_high_addr   = base[63:32];
    m.kmem_low_addr    = base[31:0];
    m.dsc_q_state.tail = tail;
    m.dsc_q_state.head = 32'hdead_0000;
    m.pkt_q_state.tail = ptail;
    m.dsc_queue_id     = 9'd17;
    return m;
  endfunction

  task automatic send(input pkt_meta_with_queues_t m, input bit exp_v,
                      input logic [63:0] ea, input logic [127:0] ed,
                      input int maxc, output bit acc);
    exp_t e;
    int n = 0;
    in_meta_data  = m;
    in_meta_valid = 1'b1;
    acc = 0;
    while (!acc && n < maxc) begin
      @(negedge clk);
      acc = in_meta_ready;
      @(posedge clk);
      #1;
      n++;
    end
    last_cycles = n;
    if (acc && exp_v) begin
      e.addr = ea;
      e.data = ed;
      sb.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic send_ok(input string name, input pkt_meta_with_queues_t m,
                         input bit exp_v, input logic [63:0] ea,
                         input logic [127:0] ed);
    bit acc;
    send(m, exp_v, ea, ed, 50, acc);
    if (!acc) chk(name, 512'd0, 512'd1);
  endtask

  task automatic idle(input int n);
    in_meta_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_meta_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk(name, 512'(n < 200), 512'd1);
  endtask

  initial begin
    bit acc;
    int accepted;
    int tot;
    rst           = 1'b1;
    in_meta_valid = 1'b0;
    in_meta_data  = '0;
    out_dsc_ready = 1'b1;
    rb_size       = 26'd1024;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(in_meta_ready), 512'd0);
    chk("rst_out_valid", 512'(out_dsc_valid), 512'd0);
    chk("rst_count", 512'(dsc_count), 512'd0);
    chk("rst_drop", 512'(dsc_drop_count), 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 512'(in_meta_ready), 512'd1);
    @(posedge clk);
    #1;

    // single entry and latency
    send_ok("single_acc", mk(1, 64'h1_0000_0000, 5, 32'h20, 3, 64), 1,
            64'h1_0000_0140, 128'hd5c00001_00000040_00000003_00000020);
    in_meta_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 512'(out_dsc_valid), 512'd0);
    @(negedge clk);
    chk("lat_cycle2", 512'(out_dsc_valid), 512'd1);
    drain("single_drain");
    chk("single_count", 512'(dsc_count), 512'd1);

    // ring wrap, back to back
    pop_cyc_q.delete();
    send_ok("wrap0", mk(1, 64'h2_0000_0000, 1022, 32'h100, 7, 128), 1,
            64'h2_0000_FF80, 128'hd5c00001_00000080_00000007_00000100);
    send_ok("wrap1", mk(1, 64'h2_0000_0000, 1023, 32'h101, 7, 128), 1,
            64'h2_0000_FFC0, 128'hd5c00001_00000080_00000007_00000101);
    send_ok("wrap2", mk(1, 64'h2_0000_0000, 1024, 32'h102, 7, 128), 1,
            64'h2_0000_0000, 128'hd5c00001_00000080_00000007_00000102);
    drain("wrap_drain");
    chk("wrap_pops", 512'(pop_cyc_q.size()), 512'd3);
    if (pop_cyc_q.size() == 3) begin
      chk("wrap_rate0", 512'(pop_cyc_q[1] - pop_cyc_q[0]), 512'd1);
      chk("wrap_rate1", 512'(pop_cyc_q[2] - pop_cyc_q[1]), 512'd1);
    end
    chk("wrap_count", 512'(dsc_count), 512'd4);

    // backpressure: 3 accepts then stall
    out_dsc_ready = 1'b0;
    accepted = 0;
    send(mk(1, 64'h8000_0000, 0, 32'h10, 1, 64), 1, 64'h8000_0000,
         128'hd5c00001_00000040_00000001_00000010, 1, acc);
    accepted += int'(acc);
    send(mk(1, 64'h8000_0000, 1, 32'h11, 1, 64), 1, 64'h8000_0040,
         128'hd5c00001_00000040_00000001_00000011, 1, acc);
    accepted += int'(acc);
    send(mk(1, 64'h8000_0000, 2, 32'h12, 1, 64), 1, 64'h8000_0080,
         128'hd5c00001_00000040_00000001_00000012, 1, acc);
    accepted += int'(acc);
    send(mk(1, 64'h8000_0000, 3, 32'h13, 1, 64), 1, 64'h8000_00C0,
         128'hd5c00001_00000040_00000001_00000013, 7, acc);
    chk("bp_accepts", 512'(accepted), 512'd3);
    chk("bp_blocked", 512'(acc), 512'd0);
    out_dsc_ready = 1'b1;
    send_ok("bp_e3", mk(1, 64'h8000_0000, 3, 32'h13, 1, 64), 1,
            64'h8000_00C0, 128'hd5c00001_00000040_00000001_00000013);
    send_ok("bp_e4", mk(1, 64'h8000_0000, 4, 32'h14, 1, 64), 1,
            64'h8000_0100, 128'hd5c00001_00000040_00000001_00000014);
    drain("bp_drain");
    chk("bp_count", 512'(dsc_count), 512'd9);

    // pass-through alternation
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      logic [63:0]  ea;
      logic [127:0] ed;
      ea = 64'h3000 + 64'((10 + i / 2) * 64);
      ed = {96'hd5c00001_00000020_00000002, 32'(32'h40 + i)};
      send_ok("pt_acc", mk(1'(i % 2), 64'h3000, 32'(10 + i / 2),
              32'(32'h40 + i), 2, 32), 1'(i % 2), ea, ed);
      tot += last_cycles;
    end
    chk("pt_no_stall", 512'(tot), 512'd8);
    drain("pt_drain");
    chk("pt_count", 512'(dsc_count), 512'd13);
    chk("pt_model_count", 512'(dsc_count), 512'(exp_cnt));

    // zero base address, tail beyond ring
`ifdef DSC_ADDR_CHECK_EN
    exp_drop = 1;
    send_ok("zero_acc", mk(1, 64'd0, 1029, 32'h55, 9, 16), 0,
            64'h140, 128'hd5c00001_00000010_00000009_00000055);
`else
    send_ok("zero_acc", mk(1, 64'd0, 1029, 32'h55, 9, 16), 1,
            64'h140, 128'hd5c00001_00000010_00000009_00000055);
`endif
    drain("zero_drain");
    idle(3);
    chk("zero_drop", 512'(dsc_drop_count), 512'(exp_drop));
    chk("zero_count", 512'(dsc_count), 512'(exp_cnt));

    // reset mid-stream with two buffered
    out_dsc_ready = 1'b0;
    send_ok("mid_e0", mk(1, 64'h4000, 1, 32'h1, 1, 8), 1, 64'h4040,
            128'hd5c00001_00000008_00000001_00000001);
    send_ok("mid_e1", mk(1, 64'h4000, 2, 32'h2, 1, 8), 1, 64'h4080,
            128'hd5c00001_00000008_00000001_00000002);
    idle(2);
    chk("mid_buffered", 512'(out_dsc_valid), 512'd1);
    rst = 1'b1;
    sb.delete();
    exp_cnt  = 0;
    exp_drop = 0;
    @(negedge clk);
    chk("mid_rst_ready", 512'(in_meta_ready), 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_valid", 512'(out_dsc_valid), 512'd0);
    chk("mid_count", 512'(dsc_count), 512'd0);
    chk("mid_drop", 512'(dsc_drop_count), 512'd0);
    out_dsc_ready = 1'b1;
    idle(6);
    send_ok("mid_after", mk(1, 64'h5000, 3, 32'h7, 4, 2), 1, 64'h50C0,
            128'hd5c00001_00000002_00000004_00000007);
    drain("mid_drain");
    chk("mid_final_count", 512'(dsc_count), 512'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
